// File: rtl/bram_pkg.sv
// ----------------------------------------------------------------------------
// bram_pkg
// Shared types and default constants for the bram_sdp_pipe slice.
//   state_t     : controller state (CLEAR sweep, RUN normal operation)
//   DATA_W_DEF  : default data word width
//   ADDR_W_DEF  : default address width (depth = 2**ADDR_W)
//   RD_LAT_DEF  : default read latency in cycles (legal 1..4)
// ----------------------------------------------------------------------------
package bram_pkg;

    localparam int DATA_W_DEF = 1028;
    localparam int ADDR_W_DEF = 8;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage : bram_pkg

// File: rtl/bram_sdp_core.sv
// ----------------------------------------------------------------------------
// bram_sdp_core
// Behavioural simple-dual-port memory: one write port, one registered read
// port. A read and a write to the same address on the same edge return the
// old content (read-first), which is what block RAM primitives give natively.
//
// Ports
//   i_clk    in   clock, rising edge
//   i_rst    in   synchronous active-high reset (read register only)
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable; read register loads only when high
//   i_raddr  in   read address
//   o_rdata  out  registered read data, holds between reads
// ----------------------------------------------------------------------------
module bram_sdp_core
    import bram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array and read register are written directly in the clocked blocks so
    // synthesis maps them onto a RAM primitive with its output register.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule : bram_sdp_core

// File: rtl/bram_sdp_pipe.sv
// ----------------------------------------------------------------------------
// bram_sdp_pipe
// Simple-dual-port RAM wrapper with power-up clear sweep and a fixed-latency
// read pipeline. After reset every word is written to zero, one address per
// cycle; only then are the user ports accepted (o_ready high).
//
// Optional feature: define BRAM_SDP_BYPASS_EN for write-first behaviour on a
// same-address same-edge read/write (forwarding register on stage 1).
// Without it the collision returns the old content (read-first).
//
// Ports
//   i_clk    in   clock, rising edge
//   i_rst    in   synchronous active-high reset
//   i_cena   in   write port enable
//   i_wea    in   write strobe (write when i_cena & i_wea)
//   i_addra  in   write address
//   i_dina   in   write data
//   i_cenb   in   read request, one word per cycle
//   i_addrb  in   read address
//   o_doutb  out  read data, holds last valid word
//   o_validb out  one-cycle strobe per returned word
//   o_ready  out  clear sweep finished, user ports accepted
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | sweeping zeros into addresses 0..DEPTH-1; user ports ignored
// RUN   | normal operation; left only through i_rst
// ----------------------------------------------------------------------------
module bram_sdp_pipe
    import bram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF   // legal range 1..4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cena,
    input  logic              i_wea,
    input  logic [ADDR_W-1:0] i_addra,
    input  logic [DATA_W-1:0] i_dina,
    input  logic              i_cenb,
    input  logic [ADDR_W-1:0] i_addrb,
    output logic [DATA_W-1:0] o_doutb,
    output logic              o_validb,
    output logic              o_ready
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [RD_LAT-1:0] valid_q, valid_d;

    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic              rd_en;
    logic [DATA_W-1:0] core_rdata;
    logic [DATA_W-1:0] stage1_data;

    // ------------------------------------------------------------------
    // FSM, clear counter and memory port steering
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        core_we    = 1'b0;
        core_waddr = i_addra;
        core_wdata = i_dina;
        rd_en      = 1'b0;

        case (state_q)
            CLEAR: begin
                core_we    = 1'b1;
                core_waddr = clr_cnt_q;
                core_wdata = '0;
                clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                core_we = i_cena & i_wea;
                rd_en   = i_cenb;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // A reset edge must not disturb memory or launch a read.
        if (i_rst) begin
            core_we = 1'b0;
            rd_en   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign o_ready = (state_q == RUN);

    // ------------------------------------------------------------------
    // Memory
    // ------------------------------------------------------------------
    bram_sdp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (core_we),
        .i_waddr (core_waddr),
        .i_wdata (core_wdata),
        .i_re    (rd_en),
        .i_raddr (i_addrb),
        .o_rdata (core_rdata)
    );

    // ------------------------------------------------------------------
    // Stage 1 data: RAM output register, optionally overridden by the
    // forwarding register when the read collided with a write.
    // ------------------------------------------------------------------
`ifdef BRAM_SDP_BYPASS_EN
    logic              fwd_sel_q, fwd_sel_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              collide;

    assign collide = rd_en & core_we & (i_addra == i_addrb);

    // Select only changes on a read so stage 1 keeps holding between reads.
    always_comb begin
        fwd_sel_d  = fwd_sel_q;
        fwd_data_d = fwd_data_q;
        if (rd_en) begin
            fwd_sel_d = collide;
        end
        if (collide) begin
            fwd_data_d = i_dina;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_sel_q  <= fwd_sel_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign stage1_data = fwd_sel_q ? fwd_data_q : core_rdata;
`else
    assign stage1_data = core_rdata;
`endif

    // ------------------------------------------------------------------
    // Valid shift register: bit 0 aligns with the RAM output register.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d    = '0;
        valid_d[0] = rd_en;
        for (int k = 1; k < RD_LAT; k++) begin
            valid_d[k] = valid_q[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign o_validb = valid_q[RD_LAT-1];

    // ------------------------------------------------------------------
    // Data pipeline beyond stage 1. Each stage loads only when the stage
    // before it holds a valid word, so the last stage keeps the most recent
    // returned word while o_validb is low.
    // ------------------------------------------------------------------
    if (RD_LAT == 1) begin : g_lat1
        assign o_doutb = stage1_data;
    end else begin : g_latn
        logic [RD_LAT-2:0][DATA_W-1:0] data_q, data_d;

        always_comb begin
            data_d = data_q;
            if (valid_q[0]) begin
                data_d[0] = stage1_data;
            end
            for (int k = 1; k < RD_LAT - 1; k++) begin
                if (valid_q[k]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign o_doutb = data_q[RD_LAT-2];
    end

endmodule : bram_sdp_pipe

// File: tb/tb_bram_sdp_pipe.sv
// ----------------------------------------------------------------------------
// tb_bram_sdp_pipe
// Directed bench for bram_sdp_pipe (default parameters). Inputs change and
// outputs are sampled on the falling clock edge.
// Honours BRAM_SDP_BYPASS_EN for the expected collision result.
// ----------------------------------------------------------------------------
module tb_bram_sdp_pipe;

    localparam int DATA_W = 1028;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 256;

    localparam logic [DATA_W-1:0] PAT_A5   = DATA_W'({129{8'hA5}});
    localparam logic [DATA_W-1:0] PAT_ONES = {DATA_W{1'b1}};

`ifdef BRAM_SDP_BYPASS_EN
    localparam logic [DATA_W-1:0] COLL_EXP = DATA_W'(8'h3C);
`else
    localparam logic [DATA_W-1:0] COLL_EXP = DATA_W'(8'h11);
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_cena;
    logic              i_wea;
    logic [ADDR_W-1:0] i_addra;
    logic [DATA_W-1:0] i_dina;
    logic              i_cenb;
    logic [ADDR_W-1:0] i_addrb;
    logic [DATA_W-1:0] o_doutb;
    logic              o_validb;
    logic              o_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    bram_sdp_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_cena   (i_cena),
        .i_wea    (i_wea),
        .i_addra  (i_addra),
        .i_dina   (i_dina),
        .i_cenb   (i_cenb),
        .i_addrb  (i_addrb),
        .o_doutb  (o_doutb),
        .o_validb (o_validb),
        .o_ready  (o_ready)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 128 bits shown)",
                     tag, act[127:0], exp[127:0]);
        end
    endtask

    // Called at a falling edge; one-cycle write.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        i_cena  = 1'b1;
        i_wea   = 1'b1;
        i_addra = a;
        i_dina  = d;
        @(negedge i_clk);
        i_cena  = 1'b0;
        i_wea   = 1'b0;
    endtask

    // Single read, optionally with a write on the same edge. Checks the
    // valid strobe arrives exactly RD_LAT cycles later and lasts one cycle.
    task automatic rd(input string tag, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] exp, input logic wen,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        i_cenb  = 1'b1;
        i_addrb = a;
        if (wen) begin
            i_cena  = 1'b1;
            i_wea   = 1'b1;
            i_addra = wa;
            i_dina  = wd;
        end
        @(negedge i_clk);
        i_cenb = 1'b0;
        i_cena = 1'b0;
        i_wea  = 1'b0;
        for (int k = 1; k < RD_LAT; k++) begin
            check({tag, "_early"}, DATA_W'(o_validb), 0);
            @(negedge i_clk);
        end
        check({tag, "_valid"}, DATA_W'(o_validb), 1);
        check({tag, "_data"}, o_doutb, exp);
        @(negedge i_clk);
        check({tag, "_pulse"}, DATA_W'(o_validb), 0);
        check({tag, "_hold"}, o_doutb, exp);
    endtask

    // Called at the falling edge where i_rst has just been released. Drives
    // user traffic at address 200 throughout the sweep; it must be ignored.
    task automatic do_clear(input string tag);
        int cnt;
        int seen;
        cnt  = 0;
        seen = 0;
        i_cena  = 1'b1;
        i_wea   = 1'b1;
        i_addra = ADDR_W'(200);
        i_dina  = PAT_ONES;
        i_cenb  = 1'b1;
        i_addrb = ADDR_W'(200);
        while (!o_ready && cnt < 1000) begin
            if (o_validb) seen++;
            cnt++;
            @(negedge i_clk);
        end
        i_cena = 1'b0;
        i_wea  = 1'b0;
        i_cenb = 1'b0;
        check({tag, "_len"}, DATA_W'(cnt), DATA_W'(DEPTH));
        check({tag, "_novalid"}, DATA_W'(seen), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        i_rst   = 1'b1;
        i_cena  = 1'b0;
        i_wea   = 1'b0;
        i_addra = '0;
        i_dina  = '0;
        i_cenb  = 1'b0;
        i_addrb = '0;
        repeat (2) @(negedge i_clk);
        check("rst_ready", DATA_W'(o_ready), 0);
        check("rst_valid", DATA_W'(o_validb), 0);
        check("rst_dout", o_doutb, 0);

        i_rst = 1'b0;
        do_clear("clr0");

        rd("idle0", ADDR_W'(0), 0, 1'b0, '0, '0);
        rd("idle128", ADDR_W'(128), 0, 1'b0, '0, '0);
        rd("idle255", ADDR_W'(255), 0, 1'b0, '0, '0);
        rd("clrtraffic200", ADDR_W'(200), 0, 1'b0, '0, '0);

        // Write then read on the very next edge returns the new word.
        wr(ADDR_W'(7), PAT_A5);
        rd("a5", ADDR_W'(7), PAT_A5, 1'b0, '0, '0);

        for (int i = 0; i < 16; i++) begin
            wr(ADDR_W'(i), DATA_W'(i));
        end
        for (int c = 0; c < 16 + RD_LAT + 3; c++) begin
            if (c >= RD_LAT && c < 16 + RD_LAT) begin
                check("b2b_valid", DATA_W'(o_validb), 1);
                check("b2b_data", o_doutb, DATA_W'(c - RD_LAT));
            end else if (c >= 16 + RD_LAT) begin
                check("b2b_idle", DATA_W'(o_validb), 0);
                check("b2b_hold", o_doutb, DATA_W'(15));
            end else begin
                check("b2b_pre", DATA_W'(o_validb), 0);
            end
            if (c < 16) begin
                i_cenb  = 1'b1;
                i_addrb = ADDR_W'(c);
            end else begin
                i_cenb = 1'b0;
            end
            @(negedge i_clk);
        end

        // Concurrent write to a different address leaves the read alone.
        rd("dist", ADDR_W'(3), DATA_W'(3), 1'b1, ADDR_W'(4), DATA_W'(16'h0077));
        rd("dist_wr", ADDR_W'(4), DATA_W'(16'h0077), 1'b0, '0, '0);

        // Same-address same-edge collision.
        wr(ADDR_W'(9), DATA_W'(8'h11));
        rd("coll", ADDR_W'(9), COLL_EXP, 1'b1, ADDR_W'(9), DATA_W'(8'h3C));
        rd("coll_after", ADDR_W'(9), DATA_W'(8'h3C), 1'b0, '0, '0);

        // Reset with reads in flight, then again at clear count 100.
        wr(ADDR_W'(50), DATA_W'(32'hDEAD_BEEF));
        seen    = 0;
        i_cenb  = 1'b1;
        i_addrb = ADDR_W'(50);
        @(negedge i_clk);
        check("inflight_pre", DATA_W'(o_validb), 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("inflight_rst_valid", DATA_W'(o_validb), 0);
        check("inflight_rst_dout", o_doutb, 0);
        check("inflight_rst_ready", DATA_W'(o_ready), 0);
        i_rst  = 1'b0;
        i_cenb = 1'b0;
        repeat (100) begin
            if (o_validb) seen++;
            @(negedge i_clk);
        end
        check("midclr_ready", DATA_W'(o_ready), 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        if (o_validb) seen++;
        i_rst = 1'b0;
        do_clear("clr2");
        check("inflight_novalid", DATA_W'(seen), 0);

        rd("post50", ADDR_W'(50), 0, 1'b0, '0, '0);
        rd("post7", ADDR_W'(7), 0, 1'b0, '0, '0);
        rd("post200", ADDR_W'(200), 0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bram_sdp_pipe
